spi_slave_if: RTL and testbench

Serial front end of the SPI slave. It deserialises MOSI frames into the 10-bit command/data word that feeds the RAM stage. For read-data commands it accepts the RAM's 8-bit response and serialises it onto MISO. Sits between the SPI pins (SS_n, MOSI, MISO) and the RAM's din/rx_valid/tx_data/tx_valid interface.

---
 rtl/spi_slave_if_if.sv | 23 ++
 rtl/spi_slave_if.sv | 110 +++++++++++
 tb/tb_spi_slave_if.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if_if.sv
// SPI slave front-end bundle: pin-side serial signals and RAM-side word handshake.
interface spi_slave_if_if #(
  parameter int unsigned RX_W = 10,
  parameter int unsigned TX_W = 8
);
  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI frames into {cmd, payload}
// words for the RAM and serialises the RAM read response onto MISO.
module spi_slave_if #(
  parameter int unsigned RX_W = 10,
  parameter int unsigned TX_W = 8
) (
  input logic           clk,
  input logic           rst,
  spi_slave_if_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TXC_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RX_W-2:0]   rx_shift;
  logic [RX_W-1:0]   rx_data;
  logic              rx_valid;
  logic              rx_done;      // word of this frame already delivered
  logic              rd_addr_flag; // a read address has been sent, next read is data
  logic [TX_W-2:0]   tx_shift;     // remaining response bits after the MSB
  logic [TXC_W-1:0]  tx_cnt;
  logic              tx_busy;
  logic              tx_done;      // readout of this frame finished
  logic              miso;

  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.MISO     = miso;

  // Frame FSM, receive shifter and readout shifter with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_done      <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      miso         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        if (!bus.SS_n) state <= CHK_CMD;
      end else if (bus.SS_n) begin
        // Deselect aborts any partial word or readout.
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_done  <= 1'b0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        tx_busy  <= 1'b0;
        tx_done  <= 1'b0;
        miso     <= 1'b0;
      end else if (state == CHK_CMD) begin
        bit_cnt <= '0;
        rx_done <= 1'b0;
        if (!bus.MOSI)         state <= WRITE;
        else if (!rd_addr_flag) state <= READ_ADD;
        else                    state <= READ_DATA;
      end else if (!rx_done) begin
        if (bit_cnt == CNT_W'(RX_W - 1)) begin
          rx_data  <= {rx_shift, bus.MOSI};
          rx_valid <= 1'b1;
          rx_done  <= 1'b1;
          bit_cnt  <= '0;
          if (state == READ_ADD) rd_addr_flag <= 1'b1;
        end else begin
          rx_shift <= {rx_shift[RX_W-3:0], bus.MOSI};
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end
      end else if (state == READ_DATA) begin
        if (tx_busy) begin
          if (tx_cnt == TXC_W'(TX_W - 1)) begin
            miso         <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b1;
            tx_cnt       <= '0;
            tx_shift     <= '0;
            rd_addr_flag <= 1'b0;
          end else begin
            miso     <= tx_shift[TX_W-2];
            tx_shift <= {tx_shift[TX_W-3:0], 1'b0};
            tx_cnt   <= tx_cnt + TXC_W'(1);
          end
        end else if (!tx_done && bus.tx_valid) begin
          miso     <= bus.tx_data[TX_W-1];
          tx_shift <= bus.tx_data[TX_W-2:0];
          tx_cnt   <= '0;
          tx_busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for the SPI slave front end: write/read frames, aborts, resets.
module tb_spi_slave_if;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_slave_if_if bus ();

  spi_slave_if dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full frame; leaves SS_n low right after the edge that raises rx_valid.
  task automatic frame(input logic dir, input logic [9:0] w, input string tag);
    logic [9:0] word;
    word = w;
    bus.SS_n = 1'b0;
    bus.MOSI = dir;
    tick();
    chk({tag, "_rv_e0"}, 32'(bus.rx_valid), 32'd0);
    tick();
    for (int i = 9; i >= 0; i--) begin
      bus.MOSI = word[i];
      tick();
      if (i > 0) chk({tag, "_rv_early"}, 32'(bus.rx_valid), 32'd0);
    end
    chk({tag, "_rv"}, 32'(bus.rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rx_data), 32'(word));
  endtask

  task automatic deselect();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] resp;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    tick();
    tick();
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_flag", 32'(dut.rd_addr_flag), 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    rst = 1'b0;

    // Write address then write data.
    frame(1'b0, 10'h005, "wr_addr");
    tick();
    chk("wr_addr_pulse_end", 32'(bus.rx_valid), 32'd0);
    chk("wr_addr_hold", 32'(bus.rx_data), 32'h005);
    deselect();
    chk("wr_addr_idle", 32'(dut.state), 32'd0);
    frame(1'b0, 10'h1A5, "wr_data");
    tick();
    chk("wr_data_pulse_end", 32'(bus.rx_valid), 32'd0);
    deselect();

    // Read address then read data with readout of 0xA5.
    frame(1'b1, 10'h205, "rd_addr");
    chk("rd_addr_flag", 32'(dut.rd_addr_flag), 32'd1);
    tick();
    chk("rd_addr_miso", 32'(bus.MISO), 32'd0);
    deselect();
    frame(1'b1, 10'h300, "rd_data");
    chk("rd_data_state", 32'(dut.state), 32'd4);
    resp = 8'hA5;
    bus.tx_data = resp;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("rd_miso_b7", 32'(bus.MISO), 32'(resp[7]));
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("rd_miso_bit", 32'(bus.MISO), 32'(resp[i]));
    end
    tick();
    chk("rd_miso_after", 32'(bus.MISO), 32'd0);
    chk("rd_flag_clr", 32'(dut.rd_addr_flag), 32'd0);
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("rd_stray_txv", 32'(bus.MISO), 32'd0);
    chk("rd_stay_state", 32'(dut.state), 32'd4);
    deselect();

    // Read-data command with no prior address goes to READ_ADD.
    do_reset();
    frame(1'b1, 10'h300, "rd_noaddr");
    chk("rd_noaddr_state", 32'(dut.state), 32'd3);
    chk("rd_noaddr_flag", 32'(dut.rd_addr_flag), 32'd1);
    tick();
    chk("rd_noaddr_miso", 32'(bus.MISO), 32'd0);
    deselect();

    // Abort after 4 payload bits, then a complete write frame.
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.MOSI = 1'(i % 2);
      tick();
      chk("abort_rv", 32'(bus.rx_valid), 32'd0);
    end
    deselect();
    chk("abort_state", 32'(dut.state), 32'd0);
    chk("abort_rv_end", 32'(bus.rx_valid), 32'd0);
    frame(1'b0, 10'h0F0, "post_abort");
    deselect();

    // Reset during the third readout bit (flag is still set).
    frame(1'b1, 10'h3C3, "rst_mid");
    chk("rst_mid_state", 32'(dut.state), 32'd4);
    bus.tx_data = 8'h5A;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("rst_mid_b7", 32'(bus.MISO), 32'd0);
    tick();
    chk("rst_mid_b6", 32'(bus.MISO), 32'd1);
    tick();
    chk("rst_mid_b5", 32'(bus.MISO), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_miso", 32'(bus.MISO), 32'd0);
    chk("rst_mid_idle", 32'(dut.state), 32'd0);
    chk("rst_mid_flag", 32'(dut.rd_addr_flag), 32'd0);
    chk("rst_mid_rv", 32'(bus.rx_valid), 32'd0);
    deselect();

    // tx_valid delayed by 5 cycles.
    frame(1'b1, 10'h011, "late_addr");
    deselect();
    frame(1'b1, 10'h300, "late_data");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("late_wait_miso", 32'(bus.MISO), 32'd0);
    end
    resp = 8'hC3;
    bus.tx_data = resp;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("late_b7", 32'(bus.MISO), 32'd1);
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("late_bit", 32'(bus.MISO), 32'(resp[i]));
    end
    tick();
    chk("late_after", 32'(bus.MISO), 32'd0);
    chk("late_flag_clr", 32'(dut.rd_addr_flag), 32'd0);
    deselect();

    // tx_valid never arrives before deselect.
    frame(1'b1, 10'h022, "abs_addr");
    deselect();
    frame(1'b1, 10'h300, "abs_data");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abs_wait_miso", 32'(bus.MISO), 32'd0);
    end
    deselect();
    chk("abs_idle", 32'(dut.state), 32'd0);
    chk("abs_miso", 32'(bus.MISO), 32'd0);
    chk("abs_flag_kept", 32'(dut.rd_addr_flag), 32'd1);
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("abs_txv_idle", 32'(bus.MISO), 32'd0);
    chk("abs_txv_state", 32'(dut.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
